// File: rtl/detector_jogada.sv
// Debounced player-button detector: accepts one clean single-button press, flags multi-button presses.
// Latency: jogada_feita rises in the cycle after the DEB-th equal sample following the first sampling edge.
// No backpressure: one pulse per press; a held button is ignored until every button is released.
module detector_jogada #(
  parameter int NBOT = 4,
  parameter int DEB  = 3
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            limpa,
  input  logic            habilita,
  input  logic [NBOT-1:0] botoes,
  output logic [NBOT-1:0] jogada,
  output logic            jogada_feita,
  output logic            invalida,
  output logic            ocupado
);

  // Counter is just wide enough to hold DEB; it stops at DEB because reaching it leaves ESTABILIZA.
  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] DEB_ULTIMO = CW'(DEB - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    ESTABILIZA,
    REGISTRA,
    ESPERA_SOLTAR
  } estado_t;

  estado_t         r_estado;
  logic [NBOT-1:0] r_amostra;
  logic [NBOT-1:0] r_jogada;
  logic [CW-1:0]   r_cnt;
  logic            r_feita;
  logic            r_invalida;

  logic w_onehot;
  logic w_igual;
  logic w_ultimo;
  logic w_alguma;

  assign w_onehot = $onehot(r_amostra);
  assign w_igual  = (botoes == r_amostra);
  assign w_ultimo = (r_cnt == DEB_ULTIMO);
  assign w_alguma = (botoes != '0);

  // Press-handling FSM; the pulse flags are set on the edge that enters REGISTRA so they line up with that state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_estado   <= OCIOSO;
      r_amostra  <= '0;
      r_jogada   <= '0;
      r_cnt      <= '0;
      r_feita    <= 1'b0;
      r_invalida <= 1'b0;
    end else begin
      r_feita    <= 1'b0;
      r_invalida <= 1'b0;
      if (limpa) begin
        r_estado  <= OCIOSO;
        r_jogada  <= '0;
        r_cnt     <= '0;
        r_amostra <= '0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            if (habilita && w_alguma) begin
              r_amostra <= botoes;
              r_cnt     <= '0;
              r_estado  <= ESTABILIZA;
            end
          end
          ESTABILIZA: begin
            if (habilita && w_igual) begin
              r_cnt <= r_cnt + CW'(1);
              if (w_ultimo) begin
                r_estado <= REGISTRA;
                if (w_onehot) begin
                  r_jogada <= r_amostra;
                  r_feita  <= 1'b1;
                end else begin
                  r_invalida <= 1'b1;
                end
              end
            end else begin
              // Bounce, release or disable: drop the candidate silently.
              r_cnt    <= '0;
              r_estado <= OCIOSO;
            end
          end
          REGISTRA: begin
            r_estado <= ESPERA_SOLTAR;
          end
          ESPERA_SOLTAR: begin
            if (!w_alguma) begin
              r_estado <= OCIOSO;
            end
          end
          default: begin
            r_estado <= OCIOSO;
          end
        endcase
      end
    end
  end

  assign jogada       = r_jogada;
  assign jogada_feita = r_feita;
  assign invalida     = r_invalida;
  assign ocupado      = (r_estado != OCIOSO);

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada (NBOT=4, DEB=3): table of per-edge vectors plus hand-written reset/counter sequences.
// Outputs are sampled 1 time unit after each rising edge.
// A bench-side play counter stands in for the downstream counter fed by jogada_feita.
module tb_detector_jogada;

  logic       clock;
  logic       rst;
  logic       limpa;
  logic       habilita;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       invalida;
  logic       ocupado;

  int n_checks;
  int n_err;
  int q_cnt;

  detector_jogada #(.NBOT(4), .DEB(3)) dut (
    .clock       (clock),
    .rst         (rst),
    .limpa       (limpa),
    .habilita    (habilita),
    .botoes      (botoes),
    .jogada      (jogada),
    .jogada_feita(jogada_feita),
    .invalida    (invalida),
    .ocupado     (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream play counter model: counts each jogada_feita cycle once (sampled mid-cycle).
  always @(negedge clock) begin
    if (jogada_feita) q_cnt = q_cnt + 1;
  end

  typedef struct {
    logic       l;
    logic       h;
    logic [3:0] b;
    logic [3:0] e_jog;
    logic       e_f;
    logic       e_i;
    logic       e_o;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(logic l, logic h, logic [3:0] b,
                              logic [3:0] ej, logic ef, logic ei, logic eo);
    vec_t v;
    v.l = l; v.h = h; v.b = b; v.e_jog = ej; v.e_f = ef; v.e_i = ei; v.e_o = eo;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(logic [3:0] b);
    habilita = 1'b1;
    botoes   = b;
    repeat (6) step();
    botoes = 4'b0000;
    repeat (2) step();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    q_cnt    = 0;
    rst      = 1'b1;
    limpa    = 1'b0;
    habilita = 1'b1;
    botoes   = 4'b0100;

    // Reset takes effect before any clock edge.
    #1;
    chk("reset_outputs", {28'd0, jogada, jogada_feita, invalida, ocupado}, 32'd0);

    @(negedge clock);
    rst    = 1'b0;
    botoes = 4'b0000;

    //             l     h     botoes   jogada   f     i     ocup
    // clean press, held 8 edges
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0));
    // bounce: 2 samples, gap, then held
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0));
    // double press held 5 edges: invalida once, jogada unchanged
    tab.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0010, 1'b0, 1'b1, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0101, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0));
    // habilita=0 gating, then accepted 1000 (ESPERA_SOLTAR ignores habilita)
    tab.push_back(mk(1'b0, 1'b0, 4'b1000, 4'b0010, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 1'b0, 4'b1000, 4'b0010, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b0010, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0));
    // limpa clears jogada; limpa mid-debounce aborts, then a fresh press
    tab.push_back(mk(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0));
    // habilita dropped during debounce aborts
    tab.push_back(mk(1'b0, 1'b1, 4'b0100, 4'b0001, 1'b0, 1'b0, 1'b1));
    tab.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0001, 1'b0, 1'b0, 1'b0));
    tab.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0));

    for (int k = 0; k < tab.size(); k++) begin
      limpa    = tab[k].l;
      habilita = tab[k].h;
      botoes   = tab[k].b;
      step();
      chk($sformatf("vec%0d", k),
          {25'd0, jogada, jogada_feita, invalida, ocupado},
          {25'd0, tab[k].e_jog, tab[k].e_f, tab[k].e_i, tab[k].e_o});
    end
    limpa = 1'b0;

    // Five clean presses into the play counter: Q steps 1..5, fim at 5.
    q_cnt = 0;
    for (int p = 1; p <= 5; p++) begin
      press(4'b0001 << (p % 4));
      chk($sformatf("count_q%0d", p), q_cnt, p);
      chk($sformatf("count_fim%0d", p), {31'd0, q_cnt == 5}, {31'd0, p == 5});
    end

    // Reset in the middle of debouncing: immediate clear, no pulse, no extra count.
    habilita = 1'b1;
    botoes   = 4'b0010;
    step();
    step();
    chk("busy_before_rst", {31'd0, ocupado}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_clear", {28'd0, jogada, jogada_feita, invalida, ocupado}, 32'd0);
    @(negedge clock);
    rst = 1'b0;
    // Button still held after release: treated as a new press from OCIOSO.
    step();
    step();
    step();
    chk("no_extra_count", q_cnt, 5);
    chk("held_not_yet", {31'd0, jogada_feita}, 32'd0);
    step();
    chk("held_new_press", {27'd0, jogada, jogada_feita}, {27'd0, 4'b0010, 1'b1});
    step();
    chk("held_single_pulse", {31'd0, jogada_feita}, 32'd0);
    botoes = 4'b0000;
    step();
    chk("idle_after_release", {31'd0, ocupado}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
